// File: rtl/seq_div_unit_if.sv
// seq_div_unit_if: request/response handshake bundle for seq_div_unit
interface seq_div_unit_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_zero;
  logic                  ovf;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/seq_div_unit.sv
// seq_div_unit: radix-2 restoring signed divider, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN to skip the iterations when divisor==0 or |dividend|<|divisor|.
module seq_div_unit #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input logic          clk,
  input logic          rst,
  seq_div_unit_if.slave bus
);
  localparam int N  = DIVIDEND_W;
  localparam int M  = DIVISOR_W;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0]  dvd, mag_n;
  logic [M-1:0]  dsr, part, mag_d;
  logic [M:0]    p_sh;
  logic [CW-1:0] cnt;
  logic          ge, sn, sd, dz, early, fire;
  assign fire  = bus.in_valid && state == IDLE;
  // Magnitude of the most negative value wraps to the same bit pattern, read as unsigned
  assign mag_n = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
  assign mag_d = bus.divisor[M-1] ? -bus.divisor : bus.divisor;
  assign p_sh  = {part, dvd[N-1]};
  assign ge    = p_sh >= {1'b0, dsr};
`ifdef DIV_EARLY_EXIT_EN
  assign early = mag_d == '0 || mag_n < N'(mag_d);
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.in_valid) state_nx = early ? FIX : CALC;
    if (state == CALC && cnt == CW'(N-1)) state_nx = FIX;
    if (state == FIX) state_nx = DONE;
    if (state == DONE && bus.out_ready) state_nx = IDLE;
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
      dvd           <= '0;
      dsr           <= '0;
      part          <= '0;
      sn            <= 1'b0;
      sd            <= 1'b0;
      dz            <= 1'b0;
      cnt           <= '0;
    end else if (fire) begin
      dvd  <= early ? '0 : mag_n;
      part <= early ? M'(mag_n) : '0;
      dsr  <= mag_d;
      sn   <= bus.dividend[N-1];
      sd   <= bus.divisor[M-1];
      dz   <= bus.divisor == '0;
      cnt  <= '0;
    end else if (state == CALC) begin
      part <= M'(ge ? p_sh - {1'b0, dsr} : p_sh);
      dvd  <= {dvd[N-2:0], ge};
      cnt  <= cnt + CW'(1);
    end else if (state == FIX) begin
      bus.quotient  <= dz ? '0 : (sn ^ sd) ? -dvd : dvd;
      bus.remainder <= dz ? '0 : sn ? -part : part;
      bus.div_zero  <= dz;
      // Only -2^(N-1) / -1 yields an unsigned quotient magnitude with the MSB set and equal signs
      bus.ovf       <= !dz && sn == sd && dvd[N-1];
    end
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: directed checks of seq_div_unit results, flags, latency and handshake.
module tb_seq_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;
`ifdef DIV_EARLY_EXIT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif
  seq_div_unit_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus ();
  seq_div_unit #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Issue a job now, then count edges after the accept edge until out_valid (t+34 -> 33 edges)
  task automatic job(input string tag, input logic [31:0] a, input logic [15:0] b,
                     input logic [31:0] eq, input logic [15:0] er,
                     input logic edz, input logic eovf, input int elat);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.in_valid = 1'b0;
    bus.dividend = 32'h5a5a_5a5a;
    bus.divisor  = 16'h0;
    chk({tag, " busy"}, 32'(bus.in_ready), 32'h0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, " lat"}, 32'(n), 32'(elat));
    chk({tag, " q"}, bus.quotient, eq);
    chk({tag, " r"}, 32'(bus.remainder), 32'(er));
    chk({tag, " flags"}, {30'h0, bus.div_zero, bus.ovf}, {30'h0, edz, eovf});
  endtask
  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, " rel"}, {30'h0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset ctl", {30'h0, bus.out_valid, bus.in_ready}, 32'h1);
    chk("reset q", bus.quotient, 32'h0);
    chk("reset r", 32'(bus.remainder), 32'h0);
    chk("reset flags", {30'h0, bus.div_zero, bus.ovf}, 32'h0);
    job("100/7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0, 33);
    release_out("100/7");
    job("-100/7", -32'sd100, 16'd7, 32'hffff_fff2, 16'hfffe, 1'b0, 1'b0, 33);
    release_out("-100/7");
    job("100/-7", 32'd100, -16'sd7, 32'hffff_fff2, 16'd2, 1'b0, 1'b0, 33);
    release_out("100/-7");
    job("-100/-7", -32'sd100, -16'sd7, 32'd14, 16'hfffe, 1'b0, 1'b0, 33);
    release_out("-100/-7");
    job("1234/0", 32'd1234, 16'd0, 32'h0, 16'h0, 1'b1, 1'b0, DZ_LAT);
    release_out("1234/0");
    job("ovf", 32'h8000_0000, 16'hffff, 32'h8000_0000, 16'h0, 1'b0, 1'b1, 33);
    release_out("ovf");
    bus.out_ready = 1'b0;
    job("bp", 32'd1000, -16'sd3, -32'sd333, 16'd1, 1'b0, 1'b0, 33);
    repeat (10) step();
    chk("bp hold ctl", {30'h0, bus.out_valid, bus.in_ready}, 32'h2);
    chk("bp hold q", bus.quotient, -32'sd333);
    chk("bp hold r", 32'(bus.remainder), 32'd1);
    release_out("bp");
    job("65535/16", 32'd65535, 16'd16, 32'd4095, 16'd15, 1'b0, 1'b0, 33);
    release_out("65535/16");
    bus.in_valid = 1'b1;
    bus.dividend = 32'd7;
    bus.divisor  = 16'd2;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst ctl", {30'h0, bus.out_valid, bus.in_ready}, 32'h1);
    chk("midrst q", bus.quotient, 32'h0);
    chk("midrst r", 32'(bus.remainder), 32'h0);
    repeat (40) step();
    chk("midrst quiet", 32'(bus.out_valid), 32'h0);
    job("9/3", 32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 1'b0, 33);
    release_out("9/3");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
